// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the 5-stage core pipeline sequencer.
//   fwd_sel_t   : execute-stage operand source select
//   RESULT_MEM  : ResultSrc encoding that marks a load
//   mem_state_t : data-memory wait FSM states
//   rd_hit      : "stage writes a non-x0 register that this source reads"
//   fwd_pick    : execute forward select, Memory stage beats Writeback
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_MEM = 2'b01;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic rd_hit(input logic [4:0] rd,
                                  input logic       we,
                                  input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

  // The Memory stage holds the younger result, so it wins over Writeback.
  function automatic fwd_sel_t fwd_pick(input logic [4:0] rs,
                                        input logic [4:0] rd_m,
                                        input logic       we_m,
                                        input logic [4:0] rd_w,
                                        input logic       we_w);
    fwd_sel_t sel;
    if (rd_hit(rd_m, we_m, rs)) begin
      sel = FWD_M;
    end else if (rd_hit(rd_w, we_w, rs)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard sequencer.
//   master : pipeline side, drives register ids / stage controls, receives
//            stall, flush, forward selects, mem_err and the perf counters
//   slave  : hazard_ctrl side
// Parameter CNT_W sizes the performance counters and must match the
// sequencer's CNT_W.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  // Pipeline state seen by the sequencer
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic             BranchD;
  logic             TakenD;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic             RegWriteE;
  logic [1:0]       ResultSrcE;
  logic             JumpE;
  logic [4:0]       RdM;
  logic             RegWriteM;
  logic [1:0]       ResultSrcM;
  logic             MemReqM;
  logic             MemReadyM;
  logic [4:0]       RdW;
  logic             RegWriteW;

  // Sequencer controls back to the pipeline
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             ForwardAD;
  logic             ForwardBD;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output Rs1D, Rs2D, BranchD, TakenD, Rs1E, Rs2E, RdE, RegWriteE,
           ResultSrcE, JumpE, RdM, RegWriteM, ResultSrcM, MemReqM,
           MemReadyM, RdW, RegWriteW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD, mem_err,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, BranchD, TakenD, Rs1E, Rs2E, RdE, RegWriteE,
           ResultSrcE, JumpE, RdM, RegWriteM, ResultSrcM, MemReqM,
           MemReadyM, RdW, RegWriteW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD, mem_err,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/forward_sel.sv
// -----------------------------------------------------------------------------
// forward_sel
// Purely combinational bypass selection.
//   Rs1E/Rs2E      : execute sources     -> fwd_ae / fwd_be (fwd_sel_t)
//   Rs1D/Rs2D      : decode sources      -> fwd_ad / fwd_bd (ALUOutM bypass
//                                           for the decode branch comparator)
//   RdM/RegWriteM  : memory-stage writer
//   RdW/RegWriteW  : writeback writer
// -----------------------------------------------------------------------------
module forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdM,
  input  logic       RegWriteM,
  input  logic [4:0] RdW,
  input  logic       RegWriteW,
  output fwd_sel_t   fwd_ae,
  output fwd_sel_t   fwd_be,
  output logic       fwd_ad,
  output logic       fwd_bd
);

  // Execute-stage operand selects
  always_comb begin
    fwd_ae = fwd_pick(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    fwd_be = fwd_pick(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  // Decode-stage branch operands can only take ALUOutM; a load in M or any
  // writer in E is handled by br_stall in the sequencer instead.
  always_comb begin
    fwd_ad = rd_hit(RdM, RegWriteM, Rs1D);
    fwd_bd = rd_hit(RdM, RegWriteM, Rs2D);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencer for the 5-stage core: stalls, flushes and forwarding
// selects, a data-memory wait FSM with watchdog, and saturating perf counters.
//   clk  : core clock
//   rst  : synchronous active-high reset
//   hz   : hazard_ctrl_if.slave (pipeline inputs, stall/flush/forward outputs,
//          mem_err, stall_cnt, flush_cnt)
// Parameters:
//   MEM_TIMEOUT : max consecutive MEM_WAIT cycles before forced release
//   CNT_W       : performance counter width
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam int               WC_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0]  TIMEOUT_V = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0]  WC_ONE    = WC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mem_state_t       state_r;
  logic [WC_W-1:0]  wait_cnt_r;
  logic             mem_err_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic             mem_stall_s;
  logic             lw_stall_s;
  logic             br_stall_s;
  logic             hold_fd_s;
  logic             flush_d_s;
  logic             flush_e_s;
  fwd_sel_t         fwd_ae_s;
  fwd_sel_t         fwd_be_s;
  logic             fwd_ad_s;
  logic             fwd_bd_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  forward_sel u_forward_sel (
    .Rs1D      (hz.Rs1D),
    .Rs2D      (hz.Rs2D),
    .Rs1E      (hz.Rs1E),
    .Rs2E      (hz.Rs2E),
    .RdM       (hz.RdM),
    .RegWriteM (hz.RegWriteM),
    .RdW       (hz.RdW),
    .RegWriteW (hz.RegWriteW),
    .fwd_ae    (fwd_ae_s),
    .fwd_be    (fwd_be_s),
    .fwd_ad    (fwd_ad_s),
    .fwd_bd    (fwd_bd_s)
  );

  // Load-use and branch-operand hazards detected in Decode
  always_comb begin
    lw_stall_s = (hz.ResultSrcE == RESULT_MEM) &&
                 (rd_hit(hz.RdE, hz.RegWriteE, hz.Rs1D) ||
                  rd_hit(hz.RdE, hz.RegWriteE, hz.Rs2D));
    // The decode comparator cannot see an E result at all, nor a load
    // result still in M, so either one holds the branch for a cycle.
    br_stall_s = hz.BranchD &&
                 (rd_hit(hz.RdE, hz.RegWriteE, hz.Rs1D) ||
                  rd_hit(hz.RdE, hz.RegWriteE, hz.Rs2D) ||
                  ((hz.ResultSrcM == RESULT_MEM) &&
                   (rd_hit(hz.RdM, hz.RegWriteM, hz.Rs1D) ||
                    rd_hit(hz.RdM, hz.RegWriteM, hz.Rs2D))));
  end

  // Memory stall: a miss in RUN stalls at once; WAIT keeps stalling until
  // the ack arrives (released in the same cycle) or the watchdog expires.
  always_comb begin
    mem_stall_s = 1'b0;
    case (state_r)
      RUN:     mem_stall_s = hz.MemReqM && !hz.MemReadyM;
      WAIT:    mem_stall_s = !hz.MemReadyM && (wait_cnt_r < TIMEOUT_V);
      default: mem_stall_s = 1'b0;
    endcase
  end

  // Stall/flush combination; a memory stall freezes D/E so redirects wait
  // for the first non-stalled cycle (TakenD/JumpE persist meanwhile).
  always_comb begin
    hold_fd_s = mem_stall_s || lw_stall_s || br_stall_s;
    flush_e_s = !mem_stall_s && (lw_stall_s || br_stall_s || hz.JumpE);
    flush_d_s = !mem_stall_s && !lw_stall_s && !br_stall_s &&
                (hz.TakenD || hz.JumpE);
  end

  // Drive pipeline controls; reset forces bubbles everywhere and no stalls
  always_comb begin
    if (rst) begin
      hz.StallF    = 1'b0;
      hz.StallD    = 1'b0;
      hz.StallE    = 1'b0;
      hz.StallM    = 1'b0;
      hz.FlushD    = 1'b1;
      hz.FlushE    = 1'b1;
      hz.FlushW    = 1'b1;
      hz.ForwardAE = FWD_RF;
      hz.ForwardBE = FWD_RF;
      hz.ForwardAD = 1'b0;
      hz.ForwardBD = 1'b0;
    end else begin
      hz.StallF    = hold_fd_s;
      hz.StallD    = hold_fd_s;
      hz.StallE    = mem_stall_s;
      hz.StallM    = mem_stall_s;
      hz.FlushD    = flush_d_s;
      hz.FlushE    = flush_e_s;
      hz.FlushW    = mem_stall_s;
      hz.ForwardAE = fwd_ae_s;
      hz.ForwardBE = fwd_be_s;
      hz.ForwardAD = fwd_ad_s;
      hz.ForwardBD = fwd_bd_s;
    end
  end

  // Data-memory wait FSM with watchdog and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= {WC_W{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (hz.MemReqM && !hz.MemReadyM) begin
            state_r    <= WAIT;
            wait_cnt_r <= WC_ONE;
          end else begin
            state_r    <= RUN;
            wait_cnt_r <= {WC_W{1'b0}};
          end
        end
        WAIT: begin
          // An ack in the expiry cycle still completes the access cleanly.
          if (hz.MemReadyM) begin
            state_r    <= RUN;
            wait_cnt_r <= {WC_W{1'b0}};
          end else if (wait_cnt_r == TIMEOUT_V) begin
            state_r    <= RUN;
            wait_cnt_r <= {WC_W{1'b0}};
            mem_err_r  <= 1'b1;
          end else begin
            state_r    <= WAIT;
            wait_cnt_r <= wait_cnt_r + WC_ONE;
          end
        end
        default: begin
          state_r    <= RUN;
          wait_cnt_r <= {WC_W{1'b0}};
        end
      endcase
    end
  end

  // Saturating stall / flush performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (hold_fd_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_d_s || flush_e_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  // Registered status outputs
  always_comb begin
    hz.mem_err   = mem_err_r;
    hz.stall_cnt = stall_cnt_r;
    hz.flush_cnt = flush_cnt_r;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Table of combinational hazard vectors, hand-written multi-cycle sequences
// (load-use, memory wait, watchdog, reset during wait) and a randomized run,
// all cross-checked against a reference model of the sequencing rules.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 5;
  localparam int CMAX = 31;

  typedef struct {
    logic [4:0] rs1d, rs2d;
    logic       branchd, takend;
    logic [4:0] rs1e, rs2e, rde;
    logic       regwritee;
    logic [1:0] resultsrce;
    logic       jumpe;
    logic [4:0] rdm;
    logic       regwritem;
    logic [1:0] resultsrcm;
    logic       memreqm, memreadym;
    logic [4:0] rdw;
    logic       regwritew;
  } in_t;

  typedef struct {
    logic       stall_fd, stall_em, flush_d, flush_e, flush_w;
    logic [1:0] fae, fbe;
    logic       fad, fbd;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  // Reference model state: outstanding access, cycles stalled on it so far,
  // error flag and counters.
  bit   m_pending;
  int   m_age;
  bit   m_err;
  int   m_scnt;
  int   m_fcnt;

  vec_t tbl[$];

  hazard_ctrl_if #(.CNT_W(CW)) hz ();

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t zin();
    in_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic out_t mk_out(input logic sfd, input logic sem, input logic fd,
                                  input logic fe, input logic fw, input logic [1:0] ae,
                                  input logic [1:0] be, input logic ad, input logic bd);
    out_t o;
    o.stall_fd = sfd; o.stall_em = sem; o.flush_d = fd; o.flush_e = fe; o.flush_w = fw;
    o.fae = ae; o.fbe = be; o.fad = ad; o.fbd = bd;
    return o;
  endfunction

  function automatic bit writes(input logic [4:0] rd, input logic we, input logic [4:0] rs);
    return (we == 1'b1) && (rd != 5'd0) && (rd == rs);
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] rs, input in_t v);
    if (writes(v.rdm, v.regwritem, rs)) return 2'd2;
    if (writes(v.rdw, v.regwritew, rs)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic out_t model_comb(input in_t v, input logic r);
    out_t o;
    bit lw, br, ms, e_dep, m_ld_dep;
    if (r) return mk_out(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    e_dep    = writes(v.rde, v.regwritee, v.rs1d) || writes(v.rde, v.regwritee, v.rs2d);
    m_ld_dep = (v.resultsrcm == 2'b01) &&
               (writes(v.rdm, v.regwritem, v.rs1d) || writes(v.rdm, v.regwritem, v.rs2d));
    lw = (v.resultsrce == 2'b01) && e_dep;
    br = v.branchd && (e_dep || m_ld_dep);
    ms = (m_pending || v.memreqm) && !v.memreadym && (m_age < TO);
    o.stall_fd = ms || lw || br;
    o.stall_em = ms;
    o.flush_w  = ms;
    o.flush_e  = !ms && (lw || br || v.jumpe);
    o.flush_d  = !ms && !lw && !br && (v.takend || v.jumpe);
    o.fae = fwd_of(v.rs1e, v);
    o.fbe = fwd_of(v.rs2e, v);
    o.fad = writes(v.rdm, v.regwritem, v.rs1d);
    o.fbd = writes(v.rdm, v.regwritem, v.rs2d);
    return o;
  endfunction

  task automatic drive(input in_t v);
    hz.Rs1D = v.rs1d;   hz.Rs2D = v.rs2d;   hz.BranchD = v.branchd; hz.TakenD = v.takend;
    hz.Rs1E = v.rs1e;   hz.Rs2E = v.rs2e;   hz.RdE = v.rde;         hz.RegWriteE = v.regwritee;
    hz.ResultSrcE = v.resultsrce; hz.JumpE = v.jumpe;
    hz.RdM = v.rdm;     hz.RegWriteM = v.regwritem; hz.ResultSrcM = v.resultsrcm;
    hz.MemReqM = v.memreqm; hz.MemReadyM = v.memreadym;
    hz.RdW = v.rdw;     hz.RegWriteW = v.regwritew;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check state.
  task automatic apply(input in_t v, output out_t s);
    out_t e;
    @(negedge clk);
    drive(v);
    #1;
    e = model_comb(v, rst);
    s = mk_out(hz.StallF, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushW,
               hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD);
    chk("StallF", hz.StallF, e.stall_fd);
    chk("StallD", hz.StallD, e.stall_fd);
    chk("StallE", hz.StallE, e.stall_em);
    chk("StallM", hz.StallM, e.stall_em);
    chk("FlushD", hz.FlushD, e.flush_d);
    chk("FlushE", hz.FlushE, e.flush_e);
    chk("FlushW", hz.FlushW, e.flush_w);
    chk("ForwardAE", hz.ForwardAE, e.fae);
    chk("ForwardBE", hz.ForwardBE, e.fbe);
    chk("ForwardAD", hz.ForwardAD, e.fad);
    chk("ForwardBD", hz.ForwardBD, e.fbd);
    @(posedge clk);
    if (rst) begin
      m_pending = 1'b0; m_age = 0; m_err = 1'b0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (e.stall_em) begin
        m_pending = 1'b1;
        m_age++;
      end else begin
        // Leaving a pending access without an ack means the watchdog fired.
        if (m_pending && !v.memreadym) m_err = 1'b1;
        m_pending = 1'b0;
        m_age = 0;
      end
      if (e.stall_fd && m_scnt < CMAX) m_scnt++;
      if ((e.flush_d || e.flush_e) && m_fcnt < CMAX) m_fcnt++;
    end
    #1;
    chk("mem_err", hz.mem_err, m_err);
    chk("stall_cnt", hz.stall_cnt, m_scnt);
    chk("flush_cnt", hz.flush_cnt, m_fcnt);
  endtask

  task automatic do_reset();
    out_t s;
    rst = 1'b1;
    apply(zin(), s);
    chk("rst_FlushW", s.flush_w, 1'b1);
    chk("rst_StallF", s.stall_fd, 1'b0);
    apply(zin(), s);
    chk("rst_stall_cnt", hz.stall_cnt, 0);
    rst = 1'b0;
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.rs1d = 5'($urandom_range(0, 3)); v.rs2d = 5'($urandom_range(0, 3));
    v.rs1e = 5'($urandom_range(0, 3)); v.rs2e = 5'($urandom_range(0, 3));
    v.rde  = 5'($urandom_range(0, 3)); v.rdm  = 5'($urandom_range(0, 3));
    v.rdw  = 5'($urandom_range(0, 3));
    v.branchd = 1'($urandom_range(0, 1)); v.takend = 1'($urandom_range(0, 1));
    v.regwritee = 1'($urandom_range(0, 1)); v.regwritem = 1'($urandom_range(0, 1));
    v.regwritew = 1'($urandom_range(0, 1)); v.jumpe = ($urandom_range(0, 5) == 0);
    v.resultsrce = 2'($urandom_range(0, 3)); v.resultsrcm = 2'($urandom_range(0, 3));
    v.memreqm = 1'($urandom_range(0, 1)); v.memreadym = ($urandom_range(0, 2) == 0);
    return v;
  endfunction

  initial begin
    in_t  t;
    out_t s;
    n_vec = 0; n_bad = 0;
    m_pending = 1'b0; m_age = 0; m_err = 1'b0; m_scnt = 0; m_fcnt = 0;
    rst = 1'b1;
    drive(zin());

    // ---- combinational vector table (no memory access in flight) ----
    t = zin(); tbl.push_back('{t, mk_out(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0)});
    t = zin(); t.rde = 5; t.resultsrce = 2'b01; t.regwritee = 1; t.rs1d = 5;
    tbl.push_back('{t, mk_out(1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 0)});
    t.rs1d = 0; t.rs2d = 5; t.takend = 1;
    tbl.push_back('{t, mk_out(1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 0)});
    t = zin(); t.rde = 0; t.resultsrce = 2'b01; t.regwritee = 1;
    tbl.push_back('{t, mk_out(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0)});
    t = zin(); t.rde = 5; t.resultsrce = 2'b01; t.regwritee = 0; t.rs1d = 5;
    tbl.push_back('{t, mk_out(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0)});
    t = zin(); t.rdm = 7; t.regwritem = 1; t.rdw = 7; t.regwritew = 1; t.rs1e = 7;
    tbl.push_back('{t, mk_out(0, 0, 0, 0, 0, 2'd2, 2'd0, 0, 0)});
    t.rdm = 0;
    tbl.push_back('{t, mk_out(0, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0)});
    t = zin(); t.rdw = 0; t.regwritew = 1; t.rs2e = 0;
    tbl.push_back('{t, mk_out(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0)});
    t = zin(); t.rdm = 4; t.regwritem = 1; t.rdw = 4; t.regwritew = 1; t.rs1e = 4; t.rs2e = 4;
    tbl.push_back('{t, mk_out(0, 0, 0, 0, 0, 2'd2, 2'd2, 0, 0)});
    t.regwritem = 0;
    tbl.push_back('{t, mk_out(0, 0, 0, 0, 0, 2'd1, 2'd1, 0, 0)});
    t = zin(); t.branchd = 1; t.rs1d = 3; t.regwritee = 1; t.rde = 3;
    tbl.push_back('{t, mk_out(1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 0)});
    t = zin(); t.branchd = 1; t.rs1d = 3; t.rdm = 3; t.regwritem = 1; t.takend = 1;
    tbl.push_back('{t, mk_out(0, 0, 1, 0, 0, 2'd0, 2'd0, 1, 0)});
    t = zin(); t.branchd = 1; t.rs2d = 9; t.rdm = 9; t.regwritem = 1; t.resultsrcm = 2'b01;
    tbl.push_back('{t, mk_out(1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 1)});
    t = zin(); t.jumpe = 1;
    tbl.push_back('{t, mk_out(0, 0, 1, 1, 0, 2'd0, 2'd0, 0, 0)});

    do_reset();
    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].i, s);
      chk($sformatf("tbl%0d_stallF", k), s.stall_fd, tbl[k].o.stall_fd);
      chk($sformatf("tbl%0d_stallE", k), s.stall_em, tbl[k].o.stall_em);
      chk($sformatf("tbl%0d_flushD", k), s.flush_d, tbl[k].o.flush_d);
      chk($sformatf("tbl%0d_flushE", k), s.flush_e, tbl[k].o.flush_e);
      chk($sformatf("tbl%0d_flushW", k), s.flush_w, tbl[k].o.flush_w);
      chk($sformatf("tbl%0d_fwdAE", k), s.fae, tbl[k].o.fae);
      chk($sformatf("tbl%0d_fwdBE", k), s.fbe, tbl[k].o.fbe);
      chk($sformatf("tbl%0d_fwdAD", k), s.fad, tbl[k].o.fad);
      chk($sformatf("tbl%0d_fwdBD", k), s.fbd, tbl[k].o.fbd);
    end

    // ---- load-use: exactly one stall cycle ----
    do_reset();
    t = zin(); t.rde = 5; t.resultsrce = 2'b01; t.regwritee = 1; t.rs1d = 5;
    apply(t, s);
    apply(zin(), s);
    chk("lw_released", s.stall_fd, 1'b0);
    chk("lw_stall_cnt", hz.stall_cnt, 1);
    chk("lw_flush_cnt", hz.flush_cnt, 1);

    // ---- 3-cycle memory wait with a pending jump ----
    do_reset();
    t = zin(); t.memreqm = 1; t.memreadym = 0; t.jumpe = 1;
    for (int k = 0; k < 3; k++) begin
      apply(t, s);
      chk("wait_stall", s.stall_em, 1'b1);
      chk("wait_flushW", s.flush_w, 1'b1);
      chk("wait_flushD", s.flush_d, 1'b0);
      chk("wait_flushE", s.flush_e, 1'b0);
    end
    t.memreadym = 1;
    apply(t, s);
    chk("ack_stall", s.stall_fd, 1'b0);
    chk("ack_flushD", s.flush_d, 1'b1);
    chk("ack_flushE", s.flush_e, 1'b1);
    chk("ack_stall_cnt", hz.stall_cnt, 3);
    chk("ack_mem_err", hz.mem_err, 1'b0);

    // ---- watchdog expiry ----
    do_reset();
    t = zin(); t.memreqm = 1; t.memreadym = 0;
    for (int k = 0; k < TO; k++) begin
      apply(t, s);
      chk("to_stall", s.stall_em, 1'b1);
    end
    apply(t, s);
    chk("to_release", s.stall_em, 1'b0);
    chk("to_mem_err", hz.mem_err, 1'b1);
    for (int k = 0; k < 3; k++) apply(zin(), s);
    chk("to_err_sticky", hz.mem_err, 1'b1);

    // ---- reset in the middle of a wait ----
    apply(t, s);
    apply(t, s);
    rst = 1'b1;
    apply(t, s);
    chk("midrst_flushD", s.flush_d, 1'b1);
    chk("midrst_flushE", s.flush_e, 1'b1);
    chk("midrst_flushW", s.flush_w, 1'b1);
    chk("midrst_mem_err", hz.mem_err, 1'b0);
    chk("midrst_stall_cnt", hz.stall_cnt, 0);
    rst = 1'b0;
    apply(zin(), s);
    chk("midrst_run", s.stall_em, 1'b0);

    // ---- randomized run against the model ----
    for (int k = 0; k < 2000; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      apply(rand_in(), s);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencer for the 5-stage core. It generates the stall, flush and forwarding selects for Fetch/Decode/Execute/Memory/Writeback, including the decode-stage branch operand forwards (ForwardAD/ForwardBD) and FlushE that feed Decode. It adds a data-memory wait FSM with watchdog timeout, and saturating stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before forced release and mem_err
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
Rs1D  in  5  decode source 1
Rs2D  in  5  decode source 2
BranchD  in  1  branch in decode
TakenD  in  1  decode branch resolved taken
Rs1E  in  5  execute source 1
Rs2E  in  5  execute source 2
RdE  in  5  execute destination
RegWriteE  in  1  execute writes rd
ResultSrcE  in  2  execute result source (01 = load)
JumpE  in  1  jal/jalr redirect resolved in execute
RdM  in  5  memory-stage destination
RegWriteM  in  1  memory-stage writes rd
ResultSrcM  in  2  memory-stage result source
MemReqM  in  1  load/store active in M
MemReadyM  in  1  data memory ack
RdW  in  5  writeback destination
RegWriteW  in  1  writeback writes rd
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
StallM  out  1  hold E/M register
FlushD  out  1  bubble F/D
FlushE  out  1  bubble D/E
FlushW  out  1  bubble M/W
ForwardAE  out  2  00 regfile, 01 ResultW, 10 ALUOutM
ForwardBE  out  2  same encoding
ForwardAD  out  1  decode operand A from ALUOutM
ForwardBD  out  1  decode operand B from ALUOutM
mem_err  out  1  sticky watchdog expiry flag
stall_cnt  out  CNT_W  cycles with StallF high
flush_cnt  out  CNT_W  cycles with FlushD or FlushE high

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- While rst=1: state=RUN, wait_cnt=0, mem_err=0, counters=0, all stalls=0, FlushD=FlushE=FlushW=1, forwards=0.
- Forwarding is combinational. For ForwardAE: if RegWriteM && RdM!=0 && RdM==Rs1E then 10. Else if RegWriteW && RdW!=0 && RdW==Rs1E then 01. Else 00. ForwardBE is the same with Rs2E. M has priority over W.
- ForwardAD = RegWriteM && RdM!=0 && RdM==Rs1D. ForwardBD is the same with Rs2D.
- lw_stall = ResultSrcE==01 && RegWriteE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- br_stall = BranchD && ((RegWriteE && RdE!=0 && RdE∈{Rs1D,Rs2D}) || (ResultSrcM==01 && RegWriteM && RdM!=0 && RdM∈{Rs1D,Rs2D})).
- mem_stall is asserted in the cycle where (RUN && MemReqM && !MemReadyM), and in every WAIT cycle where !MemReadyM and wait_cnt<MEM_TIMEOUT.
- StallF = StallD = mem_stall || lw_stall || br_stall.
- StallE = StallM = mem_stall.
- FlushW = mem_stall.
- FlushE = !mem_stall && (lw_stall || br_stall || JumpE).
- FlushD = !mem_stall && !lw_stall && !br_stall && (TakenD || JumpE).
- Priority: mem_stall suppresses all D/E flushes. Redirects are applied in the first non-stalled cycle, because the D/E instructions are frozen and TakenD/JumpE therefore persist.
- FSM RUN→WAIT: on MemReqM && !MemReadyM; wait_cnt<=1.
- FSM WAIT, MemReadyM=1: go to RUN; stall released in the same cycle (zero extra latency).
- FSM WAIT, !MemReadyM: wait_cnt++.
- FSM WAIT, wait_cnt==MEM_TIMEOUT: mem_stall=0 this cycle; mem_err<=1 (sticky until rst); go to RUN.
- Single-cycle memory (MemReadyM=1 with the request) never leaves RUN and never stalls.
- Counters saturate at all-ones and do not wrap.
- rst mid-WAIT returns to RUN next edge; the pending access is abandoned.

Decomposition:
- hazard_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10)
  - RESULT_MEM=2'b01
  - mem_state_t enum {RUN, WAIT}
- Sub-module forward_sel: combinational producing ForwardAE/BE/AD/BD.
- hazard_ctrl holds the stall/flush logic, FSM and counters.

Test Plan:
- lw x5 in E (RdE=5, ResultSrcE=01, RegWriteE=1), Rs1D=5 → StallF=StallD=FlushE=1, FlushD=0 for exactly 1 cycle; stall_cnt +1.
- RdM=7, RegWriteM=1, RdW=7, RegWriteW=1, Rs1E=7 → ForwardAE=10. With RdM=0 instead → ForwardAE=01. With Rs2E=0 and RdW=0 → ForwardBE=00.
- BranchD=1, Rs1D=3, RegWriteE=1, RdE=3 → 1-cycle br_stall. Next cycle RdM=3 (ALU op) → ForwardAD=1, no stall; TakenD=1 → FlushD=1.
- MemReqM=1, MemReadyM=0 for 3 cycles then 1 → StallF/D/E/M=1 and FlushW=1 for 3 cycles, released in the 4th; stall_cnt=3. JumpE held high throughout → FlushD=FlushE=0 during the wait, then 1 in the release cycle.
- MEM_TIMEOUT=4, MemReadyM held 0 → stall for 4 cycles, released at wait_cnt==4, mem_err=1 and stays 1 until rst.
- rst asserted during WAIT → next cycle state RUN, mem_err=0, counters 0, FlushD=FlushE=FlushW=1 while rst is high.
